deser_queue_top: RTL and testbench

Serial-to-parallel front end feeding a byte FIFO. Single bits arrive on data_in, qualified by write_in. Every 8 qualified bits form one byte, which is pushed into an internal queue. The consumer pops bytes with dequeue_in, and the popped byte is presented on queue_data_out. The block sits between a bit-serial source and a byte-oriented consumer.

---
 rtl/deser_queue_pkg.sv | 7 +
 rtl/deser_queue_if.sv | 14 +
 rtl/byte_fifo.sv | 47 ++++
 rtl/deser_shift.sv | 40 ++++
 rtl/deser_queue_top.sv | 51 +++++
 tb/tb_deser_queue_top.sv | 205 ++++++++++++++++++++
 6 files changed

// File: rtl/deser_queue_pkg.sv
// Shared defaults and types for the bit-serial to byte-queue front end.
package deser_queue_pkg;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int QUEUE_DEPTH_DEF = 8;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/deser_queue_if.sv
// Serial input strobes, pop request and popped byte between source/consumer and the queue.
interface deser_queue_if
  import deser_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  data_in;
  logic                  write_in;
  logic                  dequeue_in;
  logic [DATA_WIDTH-1:0] queue_data_out;

  modport master (output data_in, output write_in, output dequeue_in, input queue_data_out);
  modport slave  (input data_in, input write_in, input dequeue_in, output queue_data_out);
endinterface

// File: rtl/byte_fifo.sv
// Word queue with registered pop output; push is dropped when full, pop ignored when empty.
module byte_fifo
  import deser_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = QUEUE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  empty;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
    end
  end
endmodule

// File: rtl/deser_shift.sv
// Assembles MSB-first serial bits into words; pulses valid for one cycle per completed word.
module deser_shift
  import deser_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in,
  input  logic                  write_in,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  valid
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift;
  logic [CNT_W-1:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      count    <= '0;
      byte_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (write_in) begin
        shift <= {shift[DATA_WIDTH-2:0], data_in};
        if (count == LAST) begin
          count    <= '0;
          byte_out <= {shift[DATA_WIDTH-2:0], data_in};
          valid    <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/deser_queue_top.sv
// Serial-to-byte deserializer feeding a byte queue, each half with its own synchronized reset.
module deser_queue_top
  import deser_queue_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          deserializer_rst,
  input  logic          queue_rst,
  deser_queue_if.slave  bus
);
  logic [1:0]            des_sync;
  logic [1:0]            que_sync;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_valid;

  // Asynchronous assert, two-flop synchronized deassert for each reset domain.
  always_ff @(posedge clk or negedge deserializer_rst) begin
    if (!deserializer_rst) des_sync <= '0;
    else                   des_sync <= {des_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge queue_rst) begin
    if (!queue_rst) que_sync <= '0;
    else            que_sync <= {que_sync[0], 1'b1};
  end

  deser_shift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst_n    (des_sync[1]),
    .data_in  (bus.data_in),
    .write_in (bus.write_in),
    .byte_out (word),
    .valid    (word_valid)
  );

  byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (que_sync[1]),
    .push      (word_valid),
    .push_data (word),
    .pop       (bus.dequeue_in),
    .rd_data   (bus.queue_data_out)
  );
endmodule

// File: tb/tb_deser_queue_top.sv
// Directed and random stimulus for deser_queue_top against a byte-queue reference model.
module tb_deser_queue_top;
  import deser_queue_pkg::*;

  localparam int DEPTH = QUEUE_DEPTH_DEF;

  logic clk = 1'b0;
  logic deserializer_rst;
  logic queue_rst;

  deser_queue_if #(.DATA_WIDTH(DATA_WIDTH_DEF)) bus ();

  deser_queue_top #(
    .DATA_WIDTH  (DATA_WIDTH_DEF),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .deserializer_rst (deserializer_rst),
    .queue_rst        (queue_rst),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  byte_t model_q[$];
  byte_t exp_out;
  byte_t acc;
  int    nbits;
  bit    pend;
  byte_t pend_byte;

  task automatic check(input string tag, input byte_t obs, input byte_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, update the model and compare the output.
  task automatic cycle(input bit w, input bit d, input bit deq);
    int n;
    bit do_pop;
    bit do_push;
    bus.write_in   = w;
    bus.data_in    = d;
    bus.dequeue_in = deq;
    @(posedge clk);
    #1;
    n       = model_q.size();
    do_pop  = deq && (n > 0);
    do_push = pend && (n < DEPTH);
    if (do_pop)  exp_out = model_q.pop_front();
    if (do_push) model_q.push_back(pend_byte);
    pend = 1'b0;
    if (w) begin
      acc = {acc[6:0], d};
      nbits++;
      if (nbits == 8) begin
        pend      = 1'b1;
        pend_byte = acc;
        nbits     = 0;
      end
    end
    bus.write_in   = 1'b0;
    bus.dequeue_in = 1'b0;
    check("model_out", bus.queue_data_out, exp_out);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic deq();
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input byte_t b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, b[i], 1'b0);
      idle(gap);
    end
  endtask

  task automatic reset_deser();
    deserializer_rst = 1'b0;
    nbits = 0;
    pend  = 1'b0;
    idle(2);
    deserializer_rst = 1'b1;
    idle(3);
  endtask

  task automatic reset_queue();
    queue_rst = 1'b0;
    #1;
    model_q.delete();
    exp_out = 8'h00;
    pend    = 1'b0;
    check("qrst_async", bus.queue_data_out, 8'h00);
    idle(2);
    queue_rst = 1'b1;
    idle(3);
  endtask

  initial begin
    byte_t b;
    bus.data_in      = 1'b0;
    bus.write_in     = 1'b0;
    bus.dequeue_in   = 1'b0;
    deserializer_rst = 1'b1;
    queue_rst        = 1'b1;
    exp_out = 8'h00;
    acc     = 8'h00;
    nbits   = 0;
    pend    = 1'b0;
    #2;
    deserializer_rst = 1'b0;
    queue_rst        = 1'b0;
    idle(2);
    deserializer_rst = 1'b1;
    queue_rst        = 1'b1;
    idle(3);
    check("reset_out", bus.queue_data_out, 8'h00);
    deq();
    check("empty_deq", bus.queue_data_out, 8'h00);

    send_byte(8'hB2, 2);
    idle(20);
    deq();
    check("single", bus.queue_data_out, 8'hB2);

    send_byte(8'hB2, 0);
    send_byte(8'h5A, 0);
    idle(3);
    deq();
    check("two_first", bus.queue_data_out, 8'hB2);
    deq();
    check("two_second", bus.queue_data_out, 8'h5A);
    deq();
    check("two_empty", bus.queue_data_out, 8'h5A);

    for (int rep = 0; rep < 2; rep++) begin
      for (int v = 1; v <= 9; v++) send_byte(byte_t'(v), 0);
      idle(3);
      for (int k = 1; k <= 8; k++) begin
        deq();
        check("full_drain", bus.queue_data_out, byte_t'(k));
      end
      deq();
      check("full_drop", bus.queue_data_out, 8'h08);
    end

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    reset_deser();
    send_byte(8'hC3, 1);
    idle(3);
    deq();
    check("partial_rst", bus.queue_data_out, 8'hC3);

    send_byte(8'h11, 0);
    idle(3);
    b = 8'h22;
    for (int i = 7; i >= 0; i--) cycle(1'b1, b[i], 1'b0);
    deq();
    check("simul_pop", bus.queue_data_out, 8'h11);
    idle(2);
    deq();
    check("simul_next", bus.queue_data_out, 8'h22);
    deq();
    check("simul_empty", bus.queue_data_out, 8'h22);

    for (int v = 0; v < 8; v++) send_byte(byte_t'(8'hA0 + v), 0);
    idle(3);
    b = 8'hA8;
    for (int i = 7; i >= 0; i--) cycle(1'b1, b[i], 1'b0);
    deq();
    check("full_simul_pop", bus.queue_data_out, 8'hA0);
    for (int v = 1; v < 8; v++) begin
      deq();
      check("full_simul_drain", bus.queue_data_out, byte_t'(8'hA0 + v));
    end
    deq();
    check("full_simul_drop", bus.queue_data_out, 8'hA7);

    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    idle(3);
    reset_queue();
    deq();
    check("qrst_empty", bus.queue_data_out, 8'h00);

    repeat (3000) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    idle(3);
    repeat (DEPTH + 2) deq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
